// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: bus width macros, build
// defaults and the controller state encoding.
// Optional feature macro used by this slice: ICACHE_STATS_EN.
`ifndef ICACHE_DEFINES_SV
`define ICACHE_DEFINES_SV
`define CacheAddrBus [24:0]
`define CacheDataBus [31:0]
`define ICACHE_SETS 64
`define ICACHE_LINE_WORDS 4
`endif

package icache_pkg;

    localparam int ICACHE_ADDR_W = 25;
    localparam int ICACHE_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MISS_REQ  = 2'd1,
        MISS_WAIT = 2'd2,
        RESP      = 2'd3
    } icache_state_t;

endpackage

// File: rtl/icache_data_ram.sv
// Instruction cache data array: SETS*LINE_WORDS words of 32 bits, one
// synchronous write port used by the refill, one combinational read port
// used by the hit path. Contents are not reset.
module icache_data_ram
    import icache_pkg::*;
#(
    parameter int SETS       = `ICACHE_SETS,
    parameter int LINE_WORDS = `ICACHE_LINE_WORDS,
    parameter int AW         = $clog2(SETS * LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_waddr,
    input  logic [ICACHE_DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]            i_raddr,
    output logic [ICACHE_DATA_W-1:0] o_rdata
);

    logic [ICACHE_DATA_W-1:0] r_mem [SETS*LINE_WORDS];

    // Store one refill word per write strobe.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with a one-word-per-request
// refill engine. Tags and valid bits live in flops here; the data array is
// icache_data_ram. Define ICACHE_STATS_EN to add hit/miss counters.
module icache
    import icache_pkg::*;
#(
    parameter int SETS       = `ICACHE_SETS,
    parameter int LINE_WORDS = `ICACHE_LINE_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic `CacheAddrBus i_p_addr,
    input  logic               i_p_read,
    input  logic               i_p_write,
    input  logic [3:0]         i_p_byte_en,
    input  logic [31:0]        i_p_writedata,
    output logic `CacheDataBus o_p_readdata,
    output logic               o_p_readdata_valid,
    output logic               o_p_waitrequest,
    input  logic               i_flush,
    output logic [24:0]        o_m_addr,
    output logic               o_m_read,
`ifdef ICACHE_STATS_EN
    output logic [31:0]        o_hit_cnt,
    output logic [31:0]        o_miss_cnt,
`endif
    input  logic [31:0]        i_m_readdata,
    input  logic               i_m_readdata_valid,
    input  logic               i_m_waitrequest
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ICACHE_ADDR_W - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] OFF_ONE  = OFF_W'(1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(LINE_WORDS - 1);

    icache_state_t              r_state;
    logic                       r_waitreq;
    logic [SETS-1:0]            r_valid;
    logic [TAG_W-1:0]           r_tag [SETS];
    logic                       r_rvalid;
    logic [ICACHE_DATA_W-1:0]   r_rdata;
    logic                       r_mread;
    logic [ICACHE_ADDR_W-1:0]   r_addr;
    logic [OFF_W-1:0]           r_cnt;
    logic                       r_flush_pend;
    logic [ICACHE_DATA_W-1:0]   r_word;

    logic [OFF_W-1:0]           w_off;
    logic [IDX_W-1:0]           w_idx;
    logic [TAG_W-1:0]           w_tag;
    logic                       w_hit;
    logic [OFF_W-1:0]           w_fill_off;
    logic [IDX_W-1:0]           w_fill_idx;
    logic [TAG_W-1:0]           w_fill_tag;
    logic                       w_we;
    logic                       w_last;
    logic                       w_req_word;
    logic [ICACHE_DATA_W-1:0]   w_ram_rdata;
    logic                       w_unused;

    // Write-side CPU signals exist only for bus compatibility.
    assign w_unused = ^{i_p_write, i_p_byte_en, i_p_writedata};

    assign w_off = i_p_addr[OFF_W-1:0];
    assign w_idx = i_p_addr[OFF_W +: IDX_W];
    assign w_tag = i_p_addr[ICACHE_ADDR_W-1 -: TAG_W];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    assign w_fill_off = r_addr[OFF_W-1:0];
    assign w_fill_idx = r_addr[OFF_W +: IDX_W];
    assign w_fill_tag = r_addr[ICACHE_ADDR_W-1 -: TAG_W];
    assign w_we       = (r_state == MISS_WAIT) && i_m_readdata_valid;
    assign w_last     = (r_cnt == OFF_LAST);
    assign w_req_word = (r_cnt == w_fill_off);

    icache_data_ram #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_data_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr ({w_fill_idx, r_cnt}),
        .i_wdata (i_m_readdata),
        .i_raddr ({w_idx, w_off}),
        .o_rdata (w_ram_rdata)
    );

    // Controller: lookup, word-by-word refill, response and flush bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_waitreq    <= 1'b0;
            r_valid      <= '0;
            r_rvalid     <= 1'b0;
            r_rdata      <= '0;
            r_mread      <= 1'b0;
            r_addr       <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            case (r_state)
                IDLE: begin
                    if (i_flush) begin
                        r_valid <= '0;
                    end
                    if (i_p_read) begin
                        if (w_hit) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_ram_rdata;
                        end else begin
                            r_addr    <= i_p_addr;
                            r_cnt     <= '0;
                            r_mread   <= 1'b1;
                            r_waitreq <= 1'b1;
                            r_state   <= MISS_REQ;
                        end
                    end
                end
                MISS_REQ: begin
                    if (i_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (!i_m_waitrequest) begin
                        r_mread <= 1'b0;
                        r_state <= MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (i_flush) begin
                        r_flush_pend <= 1'b1;
                    end
                    if (i_m_readdata_valid) begin
                        if (w_req_word) begin
                            r_word <= i_m_readdata;
                        end
                        if (w_last) begin
                            r_valid[w_fill_idx] <= 1'b1;
                            r_rvalid            <= 1'b1;
                            r_rdata             <= w_req_word ? i_m_readdata : r_word;
                            r_state             <= RESP;
                        end else begin
                            r_cnt   <= r_cnt + OFF_ONE;
                            r_mread <= 1'b1;
                            r_state <= MISS_REQ;
                        end
                    end
                end
                RESP: begin
                    if (r_flush_pend || i_flush) begin
                        r_valid <= '0;
                    end
                    r_flush_pend <= 1'b0;
                    r_waitreq    <= 1'b0;
                    r_state      <= IDLE;
                end
                default: begin
                    r_waitreq <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Record the tag of a line when its final refill word lands.
    always_ff @(posedge clk) begin
        if (w_we && w_last) begin
            r_tag[w_fill_idx] <= w_fill_tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    // Count accepted lookups by outcome; counters wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if ((r_state == IDLE) && i_p_read) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;
`endif

    assign o_p_readdata       = r_rdata;
    assign o_p_readdata_valid = r_rvalid;
    assign o_p_waitrequest    = r_waitreq;
    assign o_m_read           = r_mread;
    assign o_m_addr           = {r_addr[ICACHE_ADDR_W-1:OFF_W], r_cnt};

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a memory responder returns addr+0x100 after two
// waitrequest cycles per request; a linear stimulus sequence checks lookups,
// refills, flush handling and reset behaviour.
module tb_icache;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [24:0] i_p_addr;
    logic        i_p_read;
    logic        i_p_write;
    logic [3:0]  i_p_byte_en;
    logic [31:0] i_p_writedata;
    logic [31:0] o_p_readdata;
    logic        o_p_readdata_valid;
    logic        o_p_waitrequest;
    logic        i_flush;
    logic [24:0] o_m_addr;
    logic        o_m_read;
    logic [31:0] i_m_readdata;
    logic        i_m_readdata_valid;
    logic        i_m_waitrequest;
`ifdef ICACHE_STATS_EN
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic [24:0] m_log [$];
    logic        m_pend = 1'b0;
    logic [24:0] m_lat  = '0;
    int          m_wcnt = 0;

    always #5 clk = ~clk;

    icache dut (
        .clk                (clk),
        .rst                (rst),
        .i_p_addr           (i_p_addr),
        .i_p_read           (i_p_read),
        .i_p_write          (i_p_write),
        .i_p_byte_en        (i_p_byte_en),
        .i_p_writedata      (i_p_writedata),
        .o_p_readdata       (o_p_readdata),
        .o_p_readdata_valid (o_p_readdata_valid),
        .o_p_waitrequest    (o_p_waitrequest),
        .i_flush            (i_flush),
        .o_m_addr           (o_m_addr),
        .o_m_read           (o_m_read),
`ifdef ICACHE_STATS_EN
        .o_hit_cnt          (o_hit_cnt),
        .o_miss_cnt         (o_miss_cnt),
`endif
        .i_m_readdata       (i_m_readdata),
        .i_m_readdata_valid (i_m_readdata_valid),
        .i_m_waitrequest    (i_m_waitrequest)
    );

    // Memory responder: two stall cycles per request, data one cycle after accept.
    initial begin
        i_m_waitrequest    = 1'b1;
        i_m_readdata_valid = 1'b0;
        i_m_readdata       = '0;
        forever begin
            @(negedge clk);
            i_m_readdata_valid = 1'b0;
            if (m_pend) begin
                i_m_readdata_valid = 1'b1;
                i_m_readdata       = 32'(m_lat) + 32'h100;
                m_pend             = 1'b0;
            end
            if (o_m_read) begin
                if (m_wcnt < 2) begin
                    i_m_waitrequest = 1'b1;
                    m_wcnt++;
                end else begin
                    i_m_waitrequest = 1'b0;
                    m_lat           = o_m_addr;
                    m_log.push_back(o_m_addr);
                    m_pend          = 1'b1;
                    m_wcnt          = 0;
                end
            end else begin
                i_m_waitrequest = 1'b1;
                m_wcnt          = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode: 0 plain read, 1 flush with the request, 2 flush in MISS_WAIT, 3 read+write
    task automatic do_read(input logic [24:0] a, input logic [31:0] exp, input int exp_nm,
                           input int mode, input string tag);
        int base;
        bit wq_ok;
        bit got;
        bit fl_done;
        base    = m_log.size();
        wq_ok   = 1'b1;
        got     = 1'b0;
        fl_done = 1'b0;
        i_p_read  = 1'b1;
        i_p_addr  = a;
        i_p_write = (mode == 3);
        i_flush   = (mode == 1);
        @(posedge clk); #1;
        i_p_read  = 1'b0;
        i_p_write = 1'b0;
        i_flush   = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (o_p_readdata_valid) begin
                got = 1'b1;
                break;
            end
            if (!o_p_waitrequest) wq_ok = 1'b0;
            i_flush = 1'b0;
            if (mode == 2 && !fl_done && m_pend && !o_m_read) begin
                i_flush = 1'b1;
                fl_done = 1'b1;
            end
            @(posedge clk); #1;
        end
        i_flush = 1'b0;
        chk({tag, " valid"}, 32'(got), 32'd1);
        chk({tag, " data"}, o_p_readdata, exp);
        chk({tag, " waitreq_fill"}, 32'(wq_ok), 32'd1);
        chk({tag, " mem_reqs"}, 32'(m_log.size() - base), 32'(exp_nm));
        if (exp_nm == LW && m_log.size() - base == LW) begin
            for (int j = 0; j < LW; j++) begin
                chk({tag, " m_addr"}, 32'(m_log[base + j]), 32'((a & ~25'h3) + 25'(j)));
            end
        end
        if (mode == 2) chk({tag, " flush_pulsed"}, 32'(fl_done), 32'd1);
        @(posedge clk); #1;
        chk({tag, " valid_drop"}, 32'(o_p_readdata_valid), 32'd0);
        chk({tag, " data_zero"}, o_p_readdata, 32'd0);
    endtask

    initial begin
        int  base;
        bit  mread_seen;
        bit  trig;

        rst           = 1'b1;
        i_p_addr      = '0;
        i_p_read      = 1'b0;
        i_p_write     = 1'b0;
        i_p_byte_en   = 4'hF;
        i_p_writedata = 32'hDEAD_BEEF;
        i_flush       = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("rst valid", 32'(o_p_readdata_valid), 32'd0);
        chk("rst data", o_p_readdata, 32'd0);
        chk("rst m_read", 32'(o_m_read), 32'd0);
        chk("rst m_addr", 32'(o_m_addr), 32'd0);
        chk("rst waitreq", 32'(o_p_waitrequest), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Cold miss on word 1 of line at index 1.
        do_read(25'h000005, 32'h105, LW, 0, "cold");

        // Four back-to-back hits across the freshly filled line.
        base       = m_log.size();
        mread_seen = 1'b0;
        for (int i = 0; i < LW; i++) begin
            i_p_read = 1'b1;
            i_p_addr = 25'h4 + 25'(i);
            @(posedge clk); #1;
            if (o_m_read) mread_seen = 1'b1;
            chk("burst valid", 32'(o_p_readdata_valid), 32'd1);
            chk("burst data", o_p_readdata, 32'h104 + 32'(i));
        end
        i_p_read = 1'b0;
        @(posedge clk); #1;
        chk("burst end valid", 32'(o_p_readdata_valid), 32'd0);
        chk("burst no m_read", 32'(mread_seen), 32'd0);
        chk("burst mem_reqs", 32'(m_log.size() - base), 32'd0);

        // Same index, different tag, then back again.
        do_read(25'h000104, 32'h204, LW, 0, "conflict");
        do_read(25'h000004, 32'h104, LW, 0, "refetch");

        // Flush during refill: response still delivered, line not retained.
        do_read(25'h000008, 32'h108, LW, 2, "flush_wait");
        do_read(25'h000008, 32'h108, LW, 0, "after_flush");
        do_read(25'h000004, 32'h104, LW, 0, "flush_all");

        // Flush in IDLE: same-cycle lookup hits, later lookups miss.
        do_read(25'h000008, 32'h108, 0, 1, "flush_idle_hit");
        do_read(25'h000004, 32'h104, LW, 0, "post_idle_flush");

        // Write-only requests produce nothing.
        base       = m_log.size();
        mread_seen = 1'b0;
        i_p_write  = 1'b1;
        i_p_addr   = 25'h000010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (o_m_read) mread_seen = 1'b1;
            chk("wr_only valid", 32'(o_p_readdata_valid), 32'd0);
        end
        i_p_write = 1'b0;
        chk("wr_only no m_read", 32'(mread_seen), 32'd0);
        chk("wr_only mem_reqs", 32'(m_log.size() - base), 32'd0);

        // Read with write asserted behaves as a read.
        do_read(25'h000004, 32'h104, 0, 3, "rd_wr");

        // Reset while the second refill word is being requested.
        i_p_read = 1'b1;
        i_p_addr = 25'h000010;
        @(posedge clk); #1;
        i_p_read = 1'b0;
        base     = m_log.size();
        trig     = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (m_log.size() == base + 1 && o_m_read) begin
                trig = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst_mid reached", 32'(trig), 32'd1);
        chk("rst_mid m_addr", 32'(o_m_addr), 32'h11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid m_read", 32'(o_m_read), 32'd0);
        chk("rst_mid waitreq", 32'(o_p_waitrequest), 32'd0);
        chk("rst_mid valid", 32'(o_p_readdata_valid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        do_read(25'h000010, 32'h110, LW, 0, "after_rst");

`ifdef ICACHE_STATS_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("stats rst hit", o_hit_cnt, 32'd0);
        chk("stats rst miss", o_miss_cnt, 32'd0);
        do_read(25'h000020, 32'h120, LW, 0, "stats_miss");
        do_read(25'h000021, 32'h121, 0, 0, "stats_hit1");
        do_read(25'h000022, 32'h122, 0, 0, "stats_hit2");
        do_read(25'h000023, 32'h123, 0, 0, "stats_hit3");
        chk("stats miss", o_miss_cnt, 32'd1);
        chk("stats hit", o_hit_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 64, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter LINE_WORDS, default 4, 32-bit words per line (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, synchronous and active-high.
REQ-005 SHALL have port i_p_addr  input  `CacheAddrBus (25)  CPU word address (word-indexed, not byte).
REQ-006 SHALL have port i_p_read  input  1  CPU read request.
REQ-007 SHALL have ports i_p_write (1), i_p_byte_en (4) and i_p_writedata (32) as inputs  bus compatibility only; ignored.
REQ-008 SHALL have port o_p_readdata  output  `CacheDataBus (32)  instruction word.
REQ-009 SHALL have port o_p_readdata_valid  output  1  o_p_readdata valid this cycle.
REQ-010 SHALL have port o_p_waitrequest  output  1  request not accepted this cycle.
REQ-011 SHALL have port i_flush  input  1  invalidate all lines (fence.i).
REQ-012 SHALL have port o_m_addr  output  25  memory word address.
REQ-013 SHALL have port o_m_read  output  1  memory read request.
REQ-014 SHALL have ports i_m_readdata (32), i_m_readdata_valid (1) and i_m_waitrequest (1) as inputs  memory read return and stall.

Function
REQ-015 SHALL split the address into offset = low log2(LINE_WORDS) bits, index = next log2(SETS) bits, and tag = the remaining bits.
REQ-016 SHALL implement FSM states IDLE, MISS_REQ, MISS_WAIT and RESP.
REQ-017 SHALL drive o_p_waitrequest as a registered function of state only: low in IDLE, high in every other state; it SHALL have no combinational path from i_p_read.
REQ-018 On a request in IDLE with i_p_read=1 that hits (valid && tag match), SHALL assert o_p_readdata_valid with the word exactly 1 cycle later; back-to-back hits SHALL sustain 1 word/cycle.
REQ-019 On a request in IDLE with i_p_read=1 that misses, SHALL latch addr and go to MISS_REQ; the request counts as accepted.
REQ-020 Refill: the fill counter SHALL start at word 0 of the line; o_m_addr = {tag, index, counter}.
REQ-021 In MISS_REQ, SHALL hold o_m_read=1 until i_m_waitrequest=0, then go to MISS_WAIT.
REQ-022 In MISS_WAIT, each i_m_readdata_valid SHALL write one word; one request SHALL be outstanding at a time; refill proceeds in strict order.
REQ-023 After the last word, SHALL set the tag and valid bits and go to RESP.
REQ-024 In RESP, SHALL assert o_p_readdata_valid for 1 cycle with the latched word, then go to IDLE.
REQ-025 i_p_read=1 with i_p_write=1 SHALL be treated as a read; i_p_write alone SHALL produce no response.
REQ-026 i_flush in IDLE SHALL clear all valid bits in that cycle; a same-cycle lookup SHALL see the pre-flush state.
REQ-027 i_flush outside IDLE SHALL be recorded and applied on return to IDLE, which also invalidates the line just filled.
REQ-028 i_m_readdata_valid outside MISS_WAIT SHALL be ignored.
REQ-029 o_p_readdata SHALL be zero whenever o_p_readdata_valid=0.

Reset
REQ-030 With rst=1, the next edge SHALL set: state IDLE, all valid bits 0, o_p_readdata_valid 0, o_p_readdata 0, o_m_read 0, o_m_addr 0, fill counter 0, pending flush 0.
REQ-031 A reset mid-refill SHALL abandon the fill with no valid bit set; o_m_read SHALL be 0 in the cycle after the edge.
REQ-032 Data RAM contents SHALL not be reset.

Configuration
REQ-033 Macro ICACHE_STATS_EN: when defined, SHALL add 32-bit outputs o_hit_cnt and o_miss_cnt, counting accepted hits and misses, wrapping at 2^32 and cleared by rst.
REQ-034 When ICACHE_STATS_EN is undefined, o_hit_cnt and o_miss_cnt SHALL be absent, and function SHALL otherwise be identical.

Structure
REQ-035 `CacheAddrBus, `CacheDataBus, the FSM state encodings and the ICACHE_SETS/ICACHE_LINE_WORDS defaults SHALL live in the shared defines file.
REQ-036 The data array SHALL be the sub-module icache_data_ram (SETS*LINE_WORDS x 32, one write port, one combinational read port); tags and valid bits SHALL be in icache flops.

Verification
REQ-037 Cold read addr 0x000005, memory returning addr+0x100 with 2-cycle waitrequest -> o_m_addr 0x4,0x5,0x6,0x7 in order; then readdata_valid with 0x105; waitrequest high throughout the fill.
REQ-038 Reads 0x4,0x5,0x6,0x7 on consecutive cycles after that fill -> four consecutive readdata_valid cycles, no o_m_read.
REQ-039 Read 0x000104 (same index, different tag) then 0x000004 -> two refills; second returns 0x104.
REQ-040 i_flush pulsed in MISS_WAIT, then read of the same address after RESP -> a new refill occurs.
REQ-041 rst asserted during the 2nd fill word -> next cycle o_m_read=0 and waitrequest=0; re-read misses and refills fully.
REQ-042 ICACHE_STATS_EN defined, sequence of 1 miss + 3 hits -> o_miss_cnt=1, o_hit_cnt=3.
